// File: rtl/game_sequencer.sv
`default_nettype none
// ============================================================================
// game_sequencer : frame strobe, speed/score, jump/duck and crash/restart
//                  control for the T-rex runner
// Revision 1.0
// ============================================================================
module game_sequencer #(
  parameter int CLK_PER_FRAME        = 1666667,
  parameter int SPEED_MIN            = 6,
  parameter int SPEED_MAX            = 13,
  parameter int SPEED_STEP_FRAMES    = 600,
  parameter int SCORE_DIV            = 40,
  parameter int RESTART_DELAY_FRAMES = 45
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_jump,
  input  logic        btn_duck,
  input  logic        collide,
  output logic        update,
  output logic [5:0]  timer,
  output logic [4:0]  speed,
  output logic        jump,
  output logic        duck,
  output logic        crash,
  output logic        restart,
  output logic [15:0] score,
  output logic [15:0] hi_score,
  output logic [1:0]  phase
);

  localparam int FCW = (CLK_PER_FRAME > 1) ? $clog2(CLK_PER_FRAME) : 1;
  localparam int SCW = (SPEED_STEP_FRAMES > 1) ? $clog2(SPEED_STEP_FRAMES) : 1;
  localparam int DCW = (RESTART_DELAY_FRAMES > 0) ? $clog2(RESTART_DELAY_FRAMES + 1) : 1;

  localparam logic [FCW-1:0] FRAME_LAST = FCW'(CLK_PER_FRAME - 1);
  localparam logic [SCW-1:0] STEP_LAST  = SCW'(SPEED_STEP_FRAMES - 1);
  localparam logic [DCW-1:0] DELAY_MAX  = DCW'(RESTART_DELAY_FRAMES);
  localparam logic [4:0]     SPD_MIN    = 5'(SPEED_MIN);
  localparam logic [4:0]     SPD_MAX    = 5'(SPEED_MAX);
  localparam logic [8:0]     DIV9       = 9'(SCORE_DIV);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PLAYING = 2'd1,
    ST_CRASHED = 2'd2
  } state_t;

  state_t         state;
  logic [FCW-1:0] frame_cnt;
  logic [SCW-1:0] step_cnt;
  logic [DCW-1:0] delay_cnt;
  logic [7:0]     frac;
  logic           armed;

  logic [SCW-1:0] step_next;
  logic [4:0]     speed_next;
  logic [8:0]     frac_sum;
  logic [7:0]     frac_wrap;
  logic           score_carry;
  logic [5:0]     timer_next;
  logic           delay_done;

  assign update = (frame_cnt == FRAME_LAST);
  assign phase  = state;

  assign step_next  = (step_cnt == STEP_LAST) ? '0 : step_cnt + 1'b1;
  assign speed_next = (step_cnt == STEP_LAST && speed != SPD_MAX) ? speed + 5'd1 : speed;
  // Distance accrues at the speed in force after this frame's step.
  assign frac_sum    = {1'b0, frac} + {4'b0, speed_next};
  assign score_carry = (frac_sum >= DIV9);
  assign frac_wrap   = 8'(frac_sum - DIV9);
  assign timer_next  = (timer == 6'd59) ? 6'd0 : timer + 6'd1;
  assign delay_done  = (delay_cnt == DELAY_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt <= '0;
    end else if (frame_cnt == FRAME_LAST) begin
      frame_cnt <= '0;
    end else begin
      frame_cnt <= frame_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      timer     <= '0;
      speed     <= SPD_MIN;
      jump      <= 1'b0;
      duck      <= 1'b0;
      crash     <= 1'b0;
      restart   <= 1'b0;
      score     <= '0;
      hi_score  <= '0;
      step_cnt  <= '0;
      delay_cnt <= '0;
      frac      <= '0;
      armed     <= 1'b0;
    end else begin
      jump    <= btn_jump & (state != ST_CRASHED);
      duck    <= btn_duck & ~btn_jump & (state != ST_CRASHED);
      restart <= 1'b0;
      if (update) begin
        case (state)
          ST_IDLE: begin
            timer <= timer_next;
            if (btn_jump) state <= ST_PLAYING;
          end
          ST_PLAYING: begin
            timer <= timer_next;
            if (collide) begin
              state <= ST_CRASHED;
              crash <= 1'b1;
              if (score > hi_score) hi_score <= score;
            end else begin
              step_cnt <= step_next;
              speed    <= speed_next;
              if (score_carry) begin
                frac <= frac_wrap;
                if (score != 16'hFFFF) score <= score + 16'd1;
              end else begin
                frac <= frac_sum[7:0];
              end
            end
          end
          ST_CRASHED: begin
            // A held jump from the crash must be released before it can restart.
            if (delay_done && armed && btn_jump) begin
              restart   <= 1'b1;
              state     <= ST_IDLE;
              crash     <= 1'b0;
              timer     <= '0;
              score     <= '0;
              frac      <= '0;
              step_cnt  <= '0;
              delay_cnt <= '0;
              armed     <= 1'b0;
              speed     <= SPD_MIN;
            end else begin
              if (!delay_done) delay_cnt <= delay_cnt + 1'b1;
              if (!btn_jump) armed <= 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire
